l5q1b: RTL and testbench



---
 rtl/l5q1b.sv | 39 +++
 tb/tb_l5q1b.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/l5q1b.sv
// 32x4 distributed-style simple dual-port RAM: synchronous write on port A, asynchronous read on DP.
// Build option L5Q1B_SPO_EN adds spo, an asynchronous read of the word at the write address.
module l5q1b #(
    parameter int DATA_WIDTH = 4,
    parameter int ADDR_WIDTH = 5,
    parameter int DEPTH      = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] d,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] dpra,
`ifdef L5Q1B_SPO_EN
    output logic [DATA_WIDTH-1:0] spo,
`endif
    output logic [DATA_WIDTH-1:0] dpo
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Asynchronous clear holds every word at zero while rst_n is low, so reset always wins over we.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            mem_q[a] <= d;
        end
    end

    assign dpo = mem_q[dpra];

`ifdef L5Q1B_SPO_EN
    assign spo = mem_q[a];
`endif

endmodule

// File: tb/tb_l5q1b.sv
// Self-checking bench for l5q1b: directed cases plus a randomized run against an array reference model.
module tb_l5q1b;

    logic       clk;
    logic       rst_n;
    logic [4:0] a;
    logic [3:0] d;
    logic       we;
    logic [4:0] dpra;
    logic [3:0] dpo;
`ifdef L5Q1B_SPO_EN
    logic [3:0] spo;
`endif

    logic [3:0] model [32];
    int tests;
    int fails;

    l5q1b #(.DATA_WIDTH(4), .ADDR_WIDTH(5), .DEPTH(32)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .a    (a),
        .d    (d),
        .we   (we),
        .dpra (dpra),
`ifdef L5Q1B_SPO_EN
        .spo  (spo),
`endif
        .dpo  (dpo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic write_word(input logic [4:0] addr, input logic [3:0] data);
        a  = addr;
        d  = data;
        we = 1'b1;
        @(posedge clk);
        model[addr] = data;
        #1;
        we = 1'b0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        a = '0; d = '0; we = 1'b0; dpra = '0;
        for (int i = 0; i < 32; i++) model[i] = 4'h0;

        // Reset state, with a write attempted during reset that must be ignored.
        we = 1'b1; a = 5'd3; d = 4'h7; dpra = 5'd3;
        @(posedge clk); #1;
        chk("reset_ignores_write", dpo, 4'h0);
        we = 1'b0;
        dpra = 5'd31; #1;
        chk("reset_dpo_31", dpo, 4'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Fill with 0xF, then clear asynchronously between edges.
        for (int i = 0; i < 32; i++) write_word(5'(i), 4'hF);
        dpra = 5'd9; #1;
        chk("fill_f", dpo, 4'hF);
        rst_n = 1'b0; #1;
        chk("async_clear_before_edge", dpo, 4'h0);
        for (int i = 0; i < 32; i++) begin
            dpra = 5'(i); #1;
            chk("reset_sweep", dpo, 4'h0);
        end
        for (int i = 0; i < 32; i++) model[i] = 4'h0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // First write after deassertion lands on the first edge.
        write_word(5'd30, 4'h6);
        dpra = 5'd30; #1;
        chk("first_write_after_reset", dpo, 4'h6);

        // Sequential write/readback.
        for (int v = 0; v < 5; v++) begin
            a = 5'(v); d = 4'(v); dpra = 5'(v); we = 1'b1;
            @(posedge clk);
            model[v] = 4'(v);
            #1;
            chk("seq_write", dpo, 4'(v));
        end
        we = 1'b0;
        for (int v = 0; v < 4; v++) begin
            dpra = 5'(v); #1;
            chk("seq_reread", dpo, 4'(v));
        end

        // Write disable.
        write_word(5'd7, 4'hA);
        a = 5'd7; d = 4'h5; we = 1'b0; dpra = 5'd7;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("we_low_holds", dpo, 4'hA);
        end

        // Independent ports.
        write_word(5'd20, 4'h9);
        a = 5'd12; d = 4'h3; we = 1'b1; dpra = 5'd20; #1;
        chk("indep_before_edge", dpo, 4'h9);
        @(posedge clk);
        model[12] = 4'h3;
        #1;
        chk("indep_after_edge", dpo, 4'h9);
        we = 1'b0;
        dpra = 5'd12; #1;
        chk("indep_switch_dpra", dpo, 4'h3);

        // Read-during-write at the same address: no bypass before the edge.
        write_word(5'd5, 4'h2);
        a = 5'd5; dpra = 5'd5; d = 4'hC; we = 1'b1; #1;
        chk("rdw_before_edge", dpo, 4'h2);
        @(posedge clk);
        model[5] = 4'hC;
        #1;
        chk("rdw_after_edge", dpo, 4'hC);
        we = 1'b0;

        // Random regression: writing phase, then read-only phase.
        for (int ph = 0; ph < 2; ph++) begin
            for (int c = 0; c < 50; c++) begin
                a    = 5'($urandom_range(0, 31));
                d    = 4'($urandom_range(0, 15));
                dpra = 5'($urandom_range(0, 31));
                we   = (ph == 0);
                #1;
                chk("rand_pre_edge", dpo, model[dpra]);
`ifdef L5Q1B_SPO_EN
                chk("rand_spo_pre", spo, model[a]);
`endif
                @(posedge clk);
                if (ph == 0) model[a] = d;
                #1;
                chk("rand_post_edge", dpo, model[dpra]);
`ifdef L5Q1B_SPO_EN
                chk("rand_spo_post", spo, model[a]);
`endif
            end
        end
        we = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
